// File: rtl/mem_responder_if.sv
// Data-memory port bundle: core A/W/D/Q port plus host request/ack port.
// master = load/store unit + host loader, slave = mem_responder.
interface mem_responder_if #(
    parameter int LEN_REG  = 32,
    parameter int MEM_ADDR = 16
);
    logic [MEM_ADDR-1:0] A;
    logic                W;
    logic [LEN_REG-1:0]  D;
    logic [LEN_REG-1:0]  Q;
    logic                host_sel;
    logic                h_req;
    logic                h_we;
    logic [MEM_ADDR-1:0] h_addr;
    logic [LEN_REG-1:0]  h_wdata;
    logic                h_ack;
    logic [LEN_REG-1:0]  h_rdata;

    modport master (
        output A, W, D, host_sel, h_req, h_we, h_addr, h_wdata,
        input  Q, h_ack, h_rdata
    );
    modport slave (
        input  A, W, D, host_sel, h_req, h_we, h_addr, h_wdata,
        output Q, h_ack, h_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: 2**MEM_ADDR x LEN_REG data memory with registered read,
// a one-entry posted-write buffer with read forwarding, and an optional
// host request/ack port (built only when MEM_HOST_PORT_EN is defined).
module mem_responder #(
    parameter int LEN_REG  = 32,
    parameter int MEM_ADDR = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    logic [LEN_REG-1:0]  mem [0:(1<<MEM_ADDR)-1];

    logic                wb_valid;
    logic [MEM_ADDR-1:0] wb_addr;
    logic [LEN_REG-1:0]  wb_data;

    logic                host_mode;
    logic                wr_en;
    logic [MEM_ADDR-1:0] wr_addr;
    logic [LEN_REG-1:0]  wr_data;
    logic [MEM_ADDR-1:0] rd_addr;
    logic [LEN_REG-1:0]  rd_data;

    logic                h_ack_q;
    logic [LEN_REG-1:0]  h_rdata_q;
    logic [LEN_REG-1:0]  q_q;

`ifdef MEM_HOST_PORT_EN
    typedef enum logic {H_IDLE, H_ACK} h_state_t;
    h_state_t h_state;
    logic     host_go;

    assign host_mode = bus.host_sel;
    assign host_go   = bus.host_sel && bus.h_req && (h_state == H_IDLE);
    assign wr_en     = host_mode ? (host_go && bus.h_we) : bus.W;
    assign wr_addr   = host_mode ? bus.h_addr  : bus.A;
    assign wr_data   = host_mode ? bus.h_wdata : bus.D;
    assign rd_addr   = host_mode ? bus.h_addr  : bus.A;

    // Host FSM: accept in H_IDLE, pulse ack with registered read data next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state   <= H_IDLE;
            h_ack_q   <= 1'b0;
            h_rdata_q <= '0;
        end else begin
            case (h_state)
                H_IDLE: begin
                    if (host_go) begin
                        h_state   <= H_ACK;
                        h_ack_q   <= 1'b1;
                        h_rdata_q <= bus.h_we ? '0 : rd_data;
                    end else begin
                        h_ack_q   <= 1'b0;
                        h_rdata_q <= '0;
                    end
                end
                default: begin
                    // ack completes even if host_sel has already dropped
                    h_state   <= H_IDLE;
                    h_ack_q   <= 1'b0;
                    h_rdata_q <= '0;
                end
            endcase
        end
    end
`else
    // Host port compiled out: inputs are sunk, outputs tied low
    logic unused_host;
    assign unused_host = ^{bus.host_sel, bus.h_req, bus.h_we, bus.h_addr, bus.h_wdata};
    assign host_mode   = 1'b0;
    assign wr_en       = bus.W;
    assign wr_addr     = bus.A;
    assign wr_data     = bus.D;
    assign rd_addr     = bus.A;
    assign h_ack_q     = 1'b0;
    assign h_rdata_q   = '0;
`endif

    // Forwarding: a pending buffered write overrides the stale array word.
    // The current cycle's write is not yet in the buffer, giving read-first.
    assign rd_data = (wb_valid && (wb_addr == rd_addr)) ? wb_data : mem[rd_addr];

    // Write buffer: load on every accepted write, drain otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= wr_en;
            if (wr_en) begin
                wb_addr <= wr_addr;
                wb_data <= wr_data;
            end
        end
    end

    // Array commit: a valid entry always retires on the next edge, whether
    // it is displaced by a new write or simply drains
    always_ff @(posedge clk) begin
        if (wb_valid)
            mem[wb_addr] <= wb_data;
    end

    // Registered core read data; forced to 0 while the host owns memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= host_mode ? '0 : rd_data;
    end

    assign bus.Q       = q_q;
    assign bus.h_ack   = h_ack_q;
    assign bus.h_rdata = h_rdata_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the data-memory interface driven by the execute stage's load/store unit. It provides 64K × 32-bit storage behind the single-cycle A/W/D/Q port, with a registered read and a one-entry posted-write buffer that has read forwarding. A second, host-side request/acknowledge port lets a loader or debugger fill and inspect memory while the core is parked.

## Interface
- LEN_REG, 32: data word width.
- MEM_ADDR, 16: word-address width; depth = 2**MEM_ADDR.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- A  in  MEM_ADDR  core word address, sampled every cycle.
- W  in  1  core store strobe; 1 means write D to A.
- D  in  LEN_REG  core store data.
- Q  out  LEN_REG  core read data (registered).
- host_sel  in  1  1 means the host owns memory and core traffic is ignored.
- h_req  in  1  host request; held high until h_ack.
- h_we  in  1  host write (1) or read (0); stable while h_req is high.
- h_addr  in  MEM_ADDR  host word address.
- h_wdata  in  LEN_REG  host write data.
- h_ack  out  1  one-cycle completion pulse.
- h_rdata  out  LEN_REG  host read data; valid only while h_ack = 1.

## Operation
- Storage: 1R1W array; contents are not reset and are undefined at power-up.
- Write buffer: holds wb_valid, wb_addr, wb_data.
  - An accepted write loads the buffer at the edge.
  - If wb_valid was already 1, the old entry is committed to the array on that same edge.
  - With no new write, a valid entry commits at the next edge and wb_valid clears.
  - The buffer never stalls either port.
- Read path: reads the array at the selected address.
  - If wb_valid = 1 and the address equals wb_addr, wb_data replaces the array data (forwarding).
- Core mode (host_sel = 0):
  - Every cycle is a read of A.
  - If W = 1, the cycle is also a write of D to A.
  - Read-first: a read and a write to the same A in one cycle returns the pre-write value.
- Host mode (host_sel = 1):
  - Core W is ignored and Q is driven to 0.
  - FSM states: H_IDLE → H_ACK → H_IDLE.
  - H_IDLE: if h_req = 1, perform the access (read of h_addr, or write of h_wdata into the buffer), then go to H_ACK.
  - H_ACK: h_ack = 1, h_rdata = read result (0 for writes), then return to H_IDLE. h_req is not sampled in H_ACK.
- host_sel falling while in H_ACK: the ack still completes. Writes the host already posted remain in the buffer and commit normally.
- host_sel = 0 while h_req = 1: the request is ignored; no ack is ever generated for it.
- Addresses are unsigned. No wrap is needed because the full address space maps 1:1 to the array.

## Timing
- Reset values: Q = 0, h_ack = 0, h_rdata = 0, wb_valid = 0, FSM = H_IDLE.
- Reset asserted mid-operation discards a pending buffered write; the array is left untouched.
- Core read latency: 1. A presented in cycle n produces Q in cycle n+1.
- Core write visibility: a read of the same address issued in cycle n+1 or later sees the new data, through forwarding in n+1 and from the array afterwards.
- Back-to-back core writes: one per cycle, sustained, with no stall.
- Host latency: h_req seen in H_IDLE in cycle n gives h_ack = 1 in cycle n+1. Maximum throughput is one host access per 2 cycles.
- Q and h_rdata are registered outputs; there is no combinational path from inputs to outputs.

## Configuration
- MEM_HOST_PORT_EN defined: host port and FSM are built as described above.
- MEM_HOST_PORT_EN undefined:
  - Ports remain present; host_sel, h_req, h_we, h_addr and h_wdata are ignored.
  - h_ack and h_rdata are tied to 0.
  - The block behaves permanently as core mode (host_sel treated as 0).

## Test plan
- Reset: assert rst asynchronously mid-cycle with W = 1 → Q = 0 and h_ack = 0 immediately; a later read of that address does not return the write's data.
- Core write then read: W = 1, A = 0x0010, D = 0xDEADBEEF in cycle 0; A = 0x0010, W = 0 in cycle 1 → Q = 0xDEADBEEF in cycle 2 (forwarded); same again in cycles 3 and 4 (from the array).
- Same-cycle read-first: address 0x0020 holds 0x11111111; write 0x22222222 to it → Q = 0x11111111 next cycle, then 0x22222222 on the following read.
- Back-to-back writes: 0x0001 ← 0xA, 0x0002 ← 0xB, 0x0001 ← 0xC in consecutive cycles, then reads of 0x0001 and 0x0002 → 0xC and 0xB.
- Host access (macro defined): host_sel = 1; write 0x00FF ← 0x12345678, then read 0x00FF → h_ack pulses one cycle each time, h_rdata = 0x12345678 on the read ack, Q = 0 throughout, core W = 1 has no effect.
- Host port compiled out: host_sel = 1 and h_req = 1 held for 10 cycles → h_ack stays 0 and core accesses proceed normally.
